// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder for the CPU MEM stage; holds the word array.
// Latency: resp_valid is high LATENCY cycles after the request cycle (accept edge + LATENCY-1).
// Backpressure: one transaction at a time; req_ready low outside IDLE, stall holds the pipeline.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-low reset
//   req_valid/_write  load/store request, held stable by the CPU until resp_valid
//   req_addr/_wdata   byte address (word index = addr[IDX_W+1:2]) and store data
//   req_ready         high in IDLE when out of reset
//   resp_valid        one-cycle response pulse; resp_rdata is load data (0 otherwise)
//   err               misaligned-access flag, only with DMEM_ALIGN_CHECK_EN defined
//   stall             req_valid && !resp_valid
// Optional feature macro: DMEM_ALIGN_CHECK_EN (alignment check, store suppression, err port).
// Parameter limits: DEPTH a power of two >= 4, LATENCY in 1..15.

module dmem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
`ifdef DMEM_ALIGN_CHECK_EN
  output logic        err,
`endif
  output logic        stall
);

  // Word-index width is always derived from DEPTH.
  localparam int IDX_W = $clog2(DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  logic [31:0]      mem [DEPTH];

  logic [1:0]       state_q;
  logic [3:0]       cnt_q;
  logic             wr_q;
  logic             mis_q;
  logic [IDX_W-1:0] idx_q;

  logic             accept;
  logic             mis;
  logic [IDX_W-1:0] req_idx;

  // Fields of the transaction that is about to respond: straight from the
  // request when LATENCY==1 (response scheduled on the accept edge),
  // otherwise from the latched copy.
  logic             fin_wr;
  logic             fin_mis;
  logic [IDX_W-1:0] fin_idx;

  // Upper address bits fall outside the array and wrap; low bits are the
  // byte offset, only inspected by the alignment check.
  logic             unused_addr_bits;
  assign unused_addr_bits = ^{req_addr[31:IDX_W+2], req_addr[1:0]};

  assign req_idx   = req_addr[IDX_W+1:2];
  assign req_ready = rst && (state_q == S_IDLE);
  assign accept    = req_valid && req_ready;
  assign stall     = req_valid && !resp_valid;

`ifdef DMEM_ALIGN_CHECK_EN
  assign mis = |req_addr[1:0];
`else
  assign mis = 1'b0;
`endif

  always_comb begin
    fin_wr  = wr_q;
    fin_mis = mis_q;
    fin_idx = idx_q;
    if (state_q == S_IDLE) begin
      fin_wr  = req_write;
      fin_mis = mis;
      fin_idx = req_idx;
    end
  end

  // The array has no reset so its contents survive rst. Stores commit on the
  // accept edge, which is what lets a following load see the new data.
  always_ff @(posedge clk) begin
    if (accept && req_write && !mis) begin
      mem[req_idx] <= req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      wr_q       <= 1'b0;
      mis_q      <= 1'b0;
      idx_q      <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
`ifdef DMEM_ALIGN_CHECK_EN
      err        <= 1'b0;
`endif
    end else begin
      // Response outputs are single-cycle; they fall back to 0 unless a
      // response is scheduled below.
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
`ifdef DMEM_ALIGN_CHECK_EN
      err        <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            wr_q  <= req_write;
            mis_q <= mis;
            idx_q <= req_idx;
            cnt_q <= CNT_INIT;
            if (LATENCY == 1) begin
              state_q    <= S_RESP;
              resp_valid <= 1'b1;
              resp_rdata <= (fin_wr || fin_mis) ? 32'd0 : mem[fin_idx];
`ifdef DMEM_ALIGN_CHECK_EN
              err        <= fin_mis;
`endif
            end else begin
              state_q <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          // The transaction completes even if req_valid drops here.
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q    <= S_RESP;
            resp_valid <= 1'b1;
            resp_rdata <= (fin_wr || fin_mis) ? 32'd0 : mem[fin_idx];
`ifdef DMEM_ALIGN_CHECK_EN
            err        <= fin_mis;
`endif
          end
        end
        S_RESP: begin
          // req_ready is low here, so the still-held request is not re-accepted.
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: three responders (LATENCY 2, 1, 4; DEPTH 256) driven by
// directed and random load/store traffic, checked against a word-array model.

module tb_dmem_responder;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst        [3];
  logic        req_valid  [3];
  logic        req_write  [3];
  logic [31:0] req_addr   [3];
  logic [31:0] req_wdata  [3];
  logic        req_ready  [3];
  logic        resp_valid [3];
  logic [31:0] resp_rdata [3];
  logic        stall      [3];
`ifdef DMEM_ALIGN_CHECK_EN
  logic        err        [3];
`endif

  logic [31:0] ref_mem [3][256];
  int total = 0;
  int bad   = 0;

  dmem_responder #(.DEPTH(256), .LATENCY(2)) u_l2 (
    .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_ready(req_ready[0]),
    .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]),
`ifdef DMEM_ALIGN_CHECK_EN
    .err(err[0]),
`endif
    .stall(stall[0]));

  dmem_responder #(.DEPTH(256), .LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_ready(req_ready[1]),
    .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]),
`ifdef DMEM_ALIGN_CHECK_EN
    .err(err[1]),
`endif
    .stall(stall[1]));

  dmem_responder #(.DEPTH(256), .LATENCY(4)) u_l4 (
    .clk(clk), .rst(rst[2]), .req_valid(req_valid[2]), .req_write(req_write[2]),
    .req_addr(req_addr[2]), .req_wdata(req_wdata[2]), .req_ready(req_ready[2]),
    .resp_valid(resp_valid[2]), .resp_rdata(resp_rdata[2]),
`ifdef DMEM_ALIGN_CHECK_EN
    .err(err[2]),
`endif
    .stall(stall[2]));

  function automatic int lat(input int k);
    case (k)
      0:       return 2;
      1:       return 1;
      default: return 4;
    endcase
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One request on instance k. Leaves the request held through the response
  // cycle, so a following call is back-to-back; call idle() to release it.
  task automatic do_req(input int k, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input bit drop);
    int          c;
    int          idx;
    bit          misal;
    bit          held;
    logic [31:0] exp_d;
    idx   = int'((addr / 4) % 256);
    misal = 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
    misal = (addr % 4) != 0;
`endif
    exp_d = (wr || misal) ? 32'd0 : ref_mem[k][idx];
    @(negedge clk);
    req_valid[k] = 1'b1;
    req_write[k] = wr;
    req_addr[k]  = addr;
    req_wdata[k] = wdata;
    #1;
    chk1("ready_at_request", req_ready[k], 1'b1);
    chk1("stall_at_request", stall[k], 1'b1);
    if (wr && !misal) ref_mem[k][idx] = wdata;
    c    = 0;
    held = 1'b1;
    do begin
      @(negedge clk);
      if (drop && c == 0) begin
        req_valid[k] = 1'b0;
        held = 1'b0;
      end
      #1;
      c++;
      if (!resp_valid[k]) begin
        chk1("stall_while_wait", stall[k], held);
        chk1("ready_while_wait", req_ready[k], 1'b0);
        chk32("rdata_idle_zero", resp_rdata[k], 32'd0);
      end
    end while (!resp_valid[k] && c < 20);
    chk32("resp_latency", 32'(c), 32'(lat(k)));
    chk32("resp_rdata", resp_rdata[k], exp_d);
    chk1("stall_in_resp", stall[k], 1'b0);
    chk1("ready_in_resp", req_ready[k], 1'b0);
`ifdef DMEM_ALIGN_CHECK_EN
    chk1("err_flag", err[k], misal);
`endif
  endtask

  task automatic idle(input int k, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      req_valid[k] = 1'b0;
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      rst[k]       = 1'b0;
      req_valid[k] = 1'b1;
      req_write[k] = 1'b0;
      req_addr[k]  = 32'd0;
      req_wdata[k] = 32'd0;
    end

    // Reset hold with a request pending.
    @(negedge clk);
    @(negedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk1("rst_ready", req_ready[k], 1'b0);
      chk1("rst_resp_valid", resp_valid[k], 1'b0);
      chk32("rst_rdata", resp_rdata[k], 32'd0);
      chk1("rst_stall", stall[k], 1'b1);
    end
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      req_valid[k] = 1'b0;
      rst[k]       = 1'b1;
    end
    @(negedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk1("ready_after_release", req_ready[k], 1'b1);
      chk1("no_resp_after_release", resp_valid[k], 1'b0);
    end

    // LATENCY=2: store then load same address, back-to-back.
    do_req(0, 1'b1, 32'h24, 32'h0000000A, 1'b0);
    do_req(0, 1'b0, 32'h24, 32'h0, 1'b0);
    chk32("store_load_0x24", resp_rdata[0], 32'h0000000A);
    // Wrap-around: 0x400 aliases word 0 with DEPTH=256.
    do_req(0, 1'b1, 32'h400, 32'hDEADBEEF, 1'b0);
    do_req(0, 1'b0, 32'h000, 32'h0, 1'b0);
    chk32("wrap_0x400", resp_rdata[0], 32'hDEADBEEF);
`ifdef DMEM_ALIGN_CHECK_EN
    do_req(0, 1'b1, 32'h26, 32'h12345678, 1'b0);
    chk1("misaligned_err", err[0], 1'b1);
    do_req(0, 1'b0, 32'h24, 32'h0, 1'b0);
    chk32("misaligned_no_write", resp_rdata[0], 32'h0000000A);
`endif
    idle(0, 2);

    // LATENCY=1.
    do_req(1, 1'b1, 32'h00, 32'h00000005, 1'b0);
    idle(1, 2);
    do_req(1, 1'b0, 32'h00, 32'h0, 1'b0);
    chk32("lat1_load", resp_rdata[1], 32'h00000005);
    idle(1, 2);

    // LATENCY=4: reset two cycles after accepting a load.
    do_req(2, 1'b1, 32'h10, 32'h00000077, 1'b0);
    idle(2, 2);
    @(negedge clk);
    req_valid[2] = 1'b1;
    req_write[2] = 1'b0;
    req_addr[2]  = 32'h10;
    @(negedge clk);
    @(negedge clk);
    rst[2] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      chk1("no_resp_after_mid_reset", resp_valid[2], 1'b0);
    end
    req_valid[2] = 1'b0;
    rst[2]       = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk1("no_stale_resp", resp_valid[2], 1'b0);
    end
    do_req(2, 1'b0, 32'h10, 32'h0, 1'b0);
    chk32("load_after_mid_reset", resp_rdata[2], 32'h00000077);
    idle(2, 2);

    // Fill every word (aligned addresses, random upper bits), then random traffic.
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 256; i++) begin
        do_req(k, 1'b1, {$urandom_range(0, 255) % 4 == 0 ? 22'd0 : 22'($urandom), 8'(i), 2'b00},
               $urandom, 1'b0);
      end
      idle(k, 1);
      for (int i = 0; i < 300; i++) begin
        do_req(k, 1'($urandom % 2), $urandom, $urandom, ($urandom % 4) == 0);
        if ($urandom % 3 == 0) idle(k, 1 + int'($urandom % 2));
      end
      idle(k, 2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
